// File: rtl/hamming74_decode_arbiter.sv
`default_nettype none
// ==========================================================================
// hamming74_decode_arbiter : round-robin shared Hamming(7,4) SEC decoder
// Rev 1.0
// ==========================================================================
module hamming74_decode_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [7*NUM_CH-1:0]   req_code,
  output logic [NUM_CH-1:0]     req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CH_W-1:0]       rsp_ch,
  output logic [3:0]            rsp_data,
  output logic                  rsp_err,
  output logic [2:0]            rsp_syn,
  input  logic                  clr_counts,
  output logic [CNT_W-1:0]      word_count,
  output logic [CNT_W-1:0]      err_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_OUT    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CH_W-1:0]  last_q;
  logic [CH_W-1:0]  ch_q;
  logic [6:0]       code_q;
  logic             rsp_valid_q;
  logic [CH_W-1:0]  rsp_ch_q;
  logic [3:0]       rsp_data_q;
  logic             rsp_err_q;
  logic [2:0]       rsp_syn_q;
  logic [CNT_W-1:0] word_q;
  logic [CNT_W-1:0] err_q;

  logic [CH_W-1:0]  grant_idx;
  logic             grant_any;
  logic [6:0]       code_sel;
  logic [2:0]       syn;
  logic [3:0]       data_cor;
  logic             rsp_hs;

  // Search starts one past the last winner, so the previous winner has lowest priority.
  always_comb begin : p_arb
    int cand;
    grant_idx = '0;
    grant_any = 1'b0;
    code_sel  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = (int'(last_q) + i) % NUM_CH;
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(cand);
        code_sel  = req_code[7*cand +: 7];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE) && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    syn = {code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6],
           code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6],
           code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6]};
    data_cor = {code_q[6], code_q[5], code_q[4], code_q[2]};
    // Syndromes 001/010/100 point at a parity bit; data passes through untouched.
    case (syn)
      3'b011:  data_cor[0] = ~data_cor[0];
      3'b101:  data_cor[1] = ~data_cor[1];
      3'b110:  data_cor[2] = ~data_cor[2];
      3'b111:  data_cor[3] = ~data_cor[3];
      default: ;
    endcase
  end

  assign rsp_hs = (state_q == S_OUT) && rsp_valid_q && rsp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_any) state_d = S_DECODE;
      S_DECODE: state_d = S_OUT;
      S_OUT:    if (rsp_hs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= CH_W'(NUM_CH - 1);
      ch_q        <= '0;
      code_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_syn_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && grant_any) begin
        code_q <= code_sel;
        ch_q   <= grant_idx;
        last_q <= grant_idx;
      end
      if (state_q == S_DECODE) begin
        rsp_valid_q <= 1'b1;
        rsp_ch_q    <= ch_q;
        rsp_data_q  <= data_cor;
        rsp_err_q   <= |syn;
        rsp_syn_q   <= syn;
      end else if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      err_q  <= '0;
    end else if (clr_counts) begin
      word_q <= '0;
      err_q  <= '0;
    end else if (rsp_hs) begin
      if (word_q != '1) word_q <= word_q + CNT_W'(1);
      if (rsp_err_q && (err_q != '1)) err_q <= err_q + CNT_W'(1);
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_ch     = rsp_ch_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_syn    = rsp_syn_q;
  assign word_count = word_q;
  assign err_count  = err_q;

endmodule
`default_nettype wire
